// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hold/flush/halt controller
//
// Purpose: merges stall requests into the hold flag bus, forwards jumps,
// flushes the front end after a taken jump, and runs the debug halt FSM.
//
// Ports:
//   clk               core clock, rising edge
//   rst               asynchronous reset, active low
//   jump_flag_i       taken jump/branch/trap from ex
//   jump_addr_i       jump target
//   hold_flag_ex_i    ex multi-cycle op busy
//   hold_flag_clint_i interrupt controller stall request
//   hold_flag_rib_i   bus arbiter stall request
//   jtag_halt_req_i   debug halt request (level)
//   stall_cnt_clr_i   synchronous clear of the stall counter
//   hold_flag_o       0 none, 1 pc, 2 if, 3 id
//   jump_flag_o       redirect pc
//   jump_addr_o       redirect target
//   halted_o          core halted for debug
//   stall_cnt_o       saturating count of stalled cycles
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_ex_i,
  input  logic        hold_flag_clint_i,
  input  logic        hold_flag_rib_i,
  input  logic        jtag_halt_req_i,
  input  logic        stall_cnt_clr_i,
  output logic [2:0]  hold_flag_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        halted_o,
  output logic [31:0] stall_cnt_o
);

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_ID   = 3'd3;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [2:0] FLUSH_LOAD = FLUSH_CYCLES[2:0];

  logic [1:0]  state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [2:0]  hold_flag;

  // Jumps are forwarded untouched in every halt state.
  assign jump_flag_o = jump_flag_i;
  assign jump_addr_o = jump_addr_i;

  always_comb begin
    hold_flag = HOLD_NONE;
    if (jump_flag_i || (flush_cnt_q != 3'd0)) begin
      hold_flag = HOLD_ID;
    end else if ((state_q == ST_HALTED) || (state_q == ST_DRAIN)) begin
      hold_flag = HOLD_ID;
    end else if (hold_flag_ex_i || hold_flag_clint_i) begin
      hold_flag = HOLD_ID;
    end else if (hold_flag_rib_i) begin
      hold_flag = HOLD_PC;
    end
  end

  assign hold_flag_o = hold_flag;

  // A new jump reloads the flush window rather than extending it.
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (jump_flag_i) begin
      flush_cnt_d = FLUSH_LOAD;
    end else if (flush_cnt_q != 3'd0) begin
      flush_cnt_d = flush_cnt_q - 3'd1;
    end
  end

  // DRAIN lets an in-flight multi-cycle op finish before halting and
  // cannot be cancelled by dropping the halt request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (jtag_halt_req_i) begin
          state_d = hold_flag_ex_i ? ST_DRAIN : ST_HALTED;
        end
      end
      ST_DRAIN: begin
        if (!hold_flag_ex_i) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (!jtag_halt_req_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_clr_i) begin
      stall_cnt_d = 32'd0;
    end else if ((hold_flag != HOLD_NONE) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 3'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign halted_o    = (state_q == ST_HALTED);
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = 32'd0;
  logic        hold_flag_ex_i = 1'b0;
  logic        hold_flag_clint_i = 1'b0;
  logic        hold_flag_rib_i = 1'b0;
  logic        jtag_halt_req_i = 1'b0;
  logic        stall_cnt_clr_i = 1'b0;
  logic [2:0]  hold_flag_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        halted_o;
  logic [31:0] stall_cnt_o;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 = running, 1 = draining, 2 = halted.
  int              m_mode  = 0;
  int              m_flush = 0;
  longint unsigned m_cnt   = 0;

  pipe_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .jump_flag_i       (jump_flag_i),
    .jump_addr_i       (jump_addr_i),
    .hold_flag_ex_i    (hold_flag_ex_i),
    .hold_flag_clint_i (hold_flag_clint_i),
    .hold_flag_rib_i   (hold_flag_rib_i),
    .jtag_halt_req_i   (jtag_halt_req_i),
    .stall_cnt_clr_i   (stall_cnt_clr_i),
    .hold_flag_o       (hold_flag_o),
    .jump_flag_o       (jump_flag_o),
    .jump_addr_o       (jump_addr_o),
    .halted_o          (halted_o),
    .stall_cnt_o       (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_hold();
    if (jump_flag_i || m_flush > 0 || m_mode != 0 || hold_flag_ex_i || hold_flag_clint_i)
      return 3;
    if (hold_flag_rib_i)
      return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_flush = 0;
    m_cnt   = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".hold"},   {29'd0, hold_flag_o}, exp_hold());
    check({tag, ".jflag"},  {31'd0, jump_flag_o}, {31'd0, jump_flag_i});
    check({tag, ".jaddr"},  jump_addr_o, jump_addr_i);
    check({tag, ".halted"}, {31'd0, halted_o}, (m_mode == 2) ? 32'd1 : 32'd0);
    check({tag, ".stall"},  stall_cnt_o, m_cnt[31:0]);
  endtask

  // One clock cycle: drive after negedge, check, then advance the model at posedge.
  task automatic step(input string tag, input logic jf, input logic [31:0] ja,
                      input logic ex, input logic clint, input logic rib,
                      input logic halt, input logic clr);
    int h;
    jump_flag_i       = jf;
    jump_addr_i       = ja;
    hold_flag_ex_i    = ex;
    hold_flag_clint_i = clint;
    hold_flag_rib_i   = rib;
    jtag_halt_req_i   = halt;
    stall_cnt_clr_i   = clr;
    #1;
    check_all(tag);
    h = exp_hold();
    @(posedge clk);
    if (clr) m_cnt = 0;
    else if (h != 0 && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (jf) m_flush = 2;
    else if (m_flush > 0) m_flush = m_flush - 1;
    case (m_mode)
      0: if (halt) m_mode = ex ? 1 : 2;
      1: if (!ex) m_mode = 2;
      default: if (!halt) m_mode = 0;
    endcase
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state with idle inputs.
    #2;
    check_all("reset");
    check("reset.hold_none", {29'd0, hold_flag_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Jump with a two-cycle flush window.
    step("jump", 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("flush1");
    idle("flush2");
    idle("post_flush");
    check("jump.stall_eq3", stall_cnt_o, 32'd3);

    // Stall priority between clint and rib.
    step("clint_rib", 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("rib_only.pre", {29'd0, hold_flag_o}, 32'd3);
    step("rib_only", 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle("prio_idle");

    // Halt request while ex busy goes through DRAIN.
    for (int i = 0; i < 5; i++)
      step("drain", 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("drain_done", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("halted.now", {31'd0, halted_o}, 32'd1);
    step("halted", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Jump while halted is forwarded, FSM stays halted.
    step("halt_jump", 1'b1, 32'hDEAD_BEEC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("halt_jump.halted", {31'd0, halted_o}, 32'd1);
    step("halt_hold", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("resume", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle("run_idle");
    check("resume.hold_none", {29'd0, hold_flag_o}, 32'd0);

    // Asynchronous reset while halted.
    step("halt_again", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("halt_again2", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    jtag_halt_req_i = 1'b0;
    rst = 1'b0;
    #1;
    model_reset();
    check("async.halted", {31'd0, halted_o}, 32'd0);
    check("async.stall", stall_cnt_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle("after_reset");
    check("after_reset.hold", {29'd0, hold_flag_o}, 32'd0);

    // Saturation of the stall counter, then clear wins over increment.
    hold_flag_ex_i = 1'b1;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    m_cnt = 64'hFFFF_FFFE;
    for (int i = 0; i < 4; i++)
      step("sat", 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sat.value", stall_cnt_o, 32'hFFFF_FFFF);
    step("sat_clr", 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("sat_clr.zero", stall_cnt_o, 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic jf, ex, cl, rb, hr, cr;
      jf = ($urandom_range(5) == 0);
      ex = ($urandom_range(3) == 0);
      cl = ($urandom_range(7) == 0);
      rb = ($urandom_range(3) == 0);
      hr = ($urandom_range(9) < 3) ? ~jtag_halt_req_i : jtag_halt_req_i;
      cr = ($urandom_range(19) == 0);
      step("rand", jf, $urandom, ex, cl, rb, hr, cr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, range 0..7: extra cycles Hold_Id is forced after a taken jump.
REQ-002 clk  input  1  core clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 jump_flag_i  input  1  taken jump/branch/trap from ex this cycle.
REQ-005 jump_addr_i  input  32  jump target.
REQ-006 hold_flag_ex_i  input  1  ex multi-cycle op (e.g. divide) busy.
REQ-007 hold_flag_clint_i  input  1  interrupt controller stall request.
REQ-008 hold_flag_rib_i  input  1  bus arbiter stall request.
REQ-009 jtag_halt_req_i  input  1  debug halt request, level.
REQ-010 stall_cnt_clr_i  input  1  synchronous clear of stall counter.
REQ-011 hold_flag_o  output  3  Hold_Flag_Bus to pc_reg/if_id/id_ex: Hold_None=0, Hold_Pc=1, Hold_If=2, Hold_Id=3.
REQ-012 jump_flag_o  output  1  redirect pc.
REQ-013 jump_addr_o  output  32  redirect target.
REQ-014 halted_o  output  1  core halted for debug.
REQ-015 stall_cnt_o  output  32  count of stalled cycles.

Function
REQ-016 Halt FSM states RUN, DRAIN, HALTED, registered; flush_cnt 3-bit register; stall_cnt 32-bit register.
REQ-017 jump_flag_o = jump_flag_i and jump_addr_o = jump_addr_i combinationally, same cycle, in every state.
REQ-018 On clock edge with jump_flag_i=1, flush_cnt loads FLUSH_CYCLES; else if flush_cnt>0 it decrements by 1.
REQ-019 hold_flag_o combinational, highest priority first: jump_flag_i=1 or flush_cnt>0 -> Hold_Id; state HALTED or DRAIN -> Hold_Id; hold_flag_ex_i -> Hold_Id; hold_flag_clint_i -> Hold_Id; hold_flag_rib_i -> Hold_Pc; otherwise Hold_None.
REQ-020 RUN: jtag_halt_req_i=1 and hold_flag_ex_i=1 -> DRAIN; jtag_halt_req_i=1 and hold_flag_ex_i=0 -> HALTED; else stay.
REQ-021 DRAIN: hold_flag_ex_i=0 -> HALTED regardless of jtag_halt_req_i; otherwise stay; DRAIN is never aborted.
REQ-022 HALTED: jtag_halt_req_i=0 -> RUN; else stay.
REQ-023 halted_o = 1 exactly when state is HALTED (registered-state decode, no input path).
REQ-024 stall_cnt: stall_cnt_clr_i=1 -> 0 (clear wins over increment); else if hold_flag_o != Hold_None and stall_cnt != FFFF_FFFF -> +1; saturates at FFFF_FFFF.
REQ-025 Jump arriving in DRAIN or HALTED is still forwarded per REQ-017 and reloads flush_cnt; halt FSM unaffected.
REQ-026 FLUSH_CYCLES=0: Hold_Id only in the jump cycle itself.
REQ-027 Jump while flush_cnt>0 reloads flush_cnt to FLUSH_CYCLES (no accumulation).

Reset
REQ-028 While rst=0: state RUN, flush_cnt 0, stall_cnt 0; halted_o 0, stall_cnt_o 0; with all request inputs 0, hold_flag_o Hold_None and jump_flag_o 0.
REQ-029 Reset asserted mid-DRAIN/HALTED/flush returns all registers to REQ-028 values immediately, without waiting for clk.
REQ-030 After rst rises, first edge evaluates transitions normally.

Verification
REQ-031 FLUSH_CYCLES=2, jump_flag_i=1 for one cycle, addr 0x0000_0100 -> jump_flag_o=1, jump_addr_o=0x100 that cycle; hold_flag_o=3 for that cycle plus next 2; then 0; stall_cnt_o=3.
REQ-032 hold_flag_rib_i=1 and hold_flag_clint_i=1 together -> hold_flag_o=3; drop clint -> hold_flag_o=1.
REQ-033 hold_flag_ex_i=1, jtag_halt_req_i=1 -> DRAIN, hold_flag_o=3, halted_o=0; drop ex after 4 cycles -> halted_o=1 next cycle; drop halt req -> RUN, halted_o=0, hold_flag_o=0.
REQ-034 Preload stall_cnt to FFFF_FFFE via continuous stall -> reaches FFFF_FFFF and holds; stall_cnt_clr_i=1 with stall active -> 0.
REQ-035 In HALTED, assert rst=0 asynchronously between edges -> halted_o=0, stall_cnt_o=0 immediately; after release, hold_flag_o=0 with inputs idle.
REQ-036 Jump during HALTED -> jump_flag_o=1 same cycle, halted_o stays 1, hold_flag_o=3.
